// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator command sequencer.
package calc_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        A    = 3'd1,
        OP   = 3'd2,
        B    = 3'd3,
        EXEC = 3'd4,
        WB   = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_MUL    = 4'd2;
    localparam logic [3:0] OP_AND    = 4'd3;
    localparam logic [3:0] MAX_DIGIT = 4'd9;

    function automatic logic one_class(input logic dig, input logic op, input logic rsel);
        return (dig & ~op & ~rsel) | (~dig & op & ~rsel) | (~dig & ~op & rsel);
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Keypad, ALU handshake and register-file write bundle around the sequencer.
interface calc_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
);
    logic              key_strobe;
    logic              isdig;
    logic              isop;
    logic              isreg;
    logic [3:0]        key_val;
    logic              alu_start;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_done;
    logic [DATA_W-1:0] alu_result;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              result_ready;
    logic              busy;
    logic              err;

    modport slave (
        input  key_strobe, isdig, isop, isreg, key_val, alu_done, alu_result,
        output alu_start, alu_op, alu_a, alu_b, rf_we, rf_waddr, rf_wdata,
               result_ready, busy, err
    );

    modport master (
        output key_strobe, isdig, isop, isreg, key_val, alu_done, alu_result,
        input  alu_start, alu_op, alu_a, alu_b, rf_we, rf_waddr, rf_wdata,
               result_ready, busy, err
    );
endinterface

// File: rtl/bcd_accum.sv
// Decimal operand accumulator: builds a value one digit at a time, up to DIGITS digits.
module bcd_accum #(
    parameter  int DATA_W = 8,
    parameter  int DIGITS = 2,
    localparam int CNT_W  = $clog2(DIGITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load_digit,
    input  logic [3:0]        digit,
    output logic [DATA_W-1:0] value,
    output logic [CNT_W-1:0]  count,
    output logic              full
);
    localparam int EXT_W = DATA_W + 4;

    logic [DATA_W-1:0] value_q;
    logic [CNT_W-1:0]  count_q;
    logic [EXT_W-1:0]  value_d;

    // Extra 4 bits keep acc*10+d exact before truncating back to DATA_W.
    assign value_d = (count_q == '0) ? EXT_W'(digit)
                                     : EXT_W'(value_q) * EXT_W'(10) + EXT_W'(digit);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            value_q <= '0;
            count_q <= '0;
        end else if (load_digit && !full) begin
            value_q <= DATA_W'(value_d);
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign value = value_q;
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DIGITS));

endmodule

// File: rtl/calc_sequencer.sv
// Sequences one keypad command (A op B reg, or A reg) through the ALU into the register file.
//   state | meaning
//   IDLE  | waiting for first digit of A
//   A     | collecting operand A digits
//   OP    | operator latched, waiting for first digit of B
//   B     | collecting operand B digits
//   EXEC  | alu_start held until alu_done
//   WB    | one-cycle register-file write
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIGITS = 2,
    parameter int REG_AW = 2
) (
    input logic             clk,
    input logic             rst,
    calc_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(DIGITS + 1);

    state_t            state_q;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic              alu_start_q;
    logic              rf_we_q;
    logic [REG_AW-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;
    logic              result_ready_q;
    logic              busy_q;
    logic              err_q;

    logic [DATA_W-1:0] val_a, val_b;
    logic [CNT_W-1:0]  count_a, count_b;
    logic              full_a, full_b;
    logic              in_busy, key_ok, key_bad, dig_ok, dig_bad, op_k, reg_k;
    logic              load_a, load_b, clear_acc;
    logic              unused_cnt;

    assign in_busy = (state_q == EXEC) || (state_q == WB);
    assign key_ok  = bus.key_strobe && !in_busy && one_class(bus.isdig, bus.isop, bus.isreg);
    assign key_bad = bus.key_strobe && !in_busy && !one_class(bus.isdig, bus.isop, bus.isreg);
    assign dig_ok  = key_ok && bus.isdig && (bus.key_val <= MAX_DIGIT);
    assign dig_bad = key_ok && bus.isdig && (bus.key_val > MAX_DIGIT);
    assign op_k    = key_ok && bus.isop;
    assign reg_k   = key_ok && bus.isreg;

    assign load_a    = dig_ok && ((state_q == IDLE) || (state_q == A));
    assign load_b    = dig_ok && ((state_q == OP) || (state_q == B));
    assign clear_acc = (state_q == WB);
    assign unused_cnt = ^{count_a, count_b};

    bcd_accum #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_acc_a (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_acc),
        .load_digit (load_a),
        .digit      (bus.key_val),
        .value      (val_a),
        .count      (count_a),
        .full       (full_a)
    );

    bcd_accum #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_acc_b (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_acc),
        .load_digit (load_b),
        .digit      (bus.key_val),
        .value      (val_b),
        .count      (count_b),
        .full       (full_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            op_q           <= OP_ADD;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_start_q    <= 1'b0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            result_ready_q <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            rf_we_q        <= 1'b0;
            result_ready_q <= 1'b0;
            err_q          <= key_bad || dig_bad;
            case (state_q)
                IDLE: begin
                    if (dig_ok)
                        state_q <= A;
                    else if (op_k || reg_k)
                        err_q <= 1'b1;
                end
                A: begin
                    if (dig_ok && full_a) begin
                        err_q <= 1'b1;
                    end else if (op_k) begin
                        op_q    <= bus.key_val;
                        state_q <= OP;
                    end else if (reg_k) begin
                        rf_waddr_q     <= bus.key_val[REG_AW-1:0];
                        rf_wdata_q     <= val_a;
                        rf_we_q        <= 1'b1;
                        result_ready_q <= 1'b1;
                        busy_q         <= 1'b1;
                        state_q        <= WB;
                    end
                end
                OP: begin
                    if (dig_ok)
                        state_q <= B;
                    else if (op_k)
                        op_q <= bus.key_val;
                    else if (reg_k)
                        err_q <= 1'b1;
                end
                B: begin
                    if ((dig_ok && full_b) || op_k) begin
                        err_q <= 1'b1;
                    end else if (reg_k) begin
                        rf_waddr_q  <= bus.key_val[REG_AW-1:0];
                        alu_a_q     <= val_a;
                        alu_b_q     <= val_b;
                        alu_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    if (alu_start_q && bus.alu_done) begin
                        rf_wdata_q     <= bus.alu_result;
                        rf_we_q        <= 1'b1;
                        result_ready_q <= 1'b1;
                        alu_start_q    <= 1'b0;
                        state_q        <= WB;
                    end
                end
                WB: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.alu_start    = alu_start_q;
    assign bus.alu_op       = op_q;
    assign bus.alu_a        = alu_a_q;
    assign bus.alu_b        = alu_b_q;
    assign bus.rf_we        = rf_we_q;
    assign bus.rf_waddr     = rf_waddr_q;
    assign bus.rf_wdata     = rf_wdata_q;
    assign bus.result_ready = result_ready_q;
    assign bus.busy         = busy_q;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed command scenarios plus random key streams against a digit-list model.
module tb_calc_sequencer;
    localparam int DATA_W = 8;
    localparam int DIGITS = 2;
    localparam int REG_AW = 2;
    localparam int MASK   = (1 << DATA_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    calc_sequencer_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

    calc_sequencer #(.DATA_W(DATA_W), .DIGITS(DIGITS), .REG_AW(REG_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: the command is just the digit lists typed so far and the current operator.
    int m_a[$];
    int m_b[$];
    bit m_have_op;
    int m_op;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int q_value(input int q[$]);
        int v = 0;
        foreach (q[i]) v = v * 10 + q[i];
        return v & MASK;
    endfunction

    function automatic int alu_model(input int op, input int a, input int b);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a * b;
            3:       r = a & b;
            default: r = a ^ b;
        endcase
        return r & MASK;
    endfunction

    task automatic model_clear();
        m_a.delete();
        m_b.delete();
        m_have_op = 0;
        m_op = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_key(input bit d, input bit o, input bit r, input int v);
        bus.key_strobe = 1'b1;
        bus.isdig = d;
        bus.isop = o;
        bus.isreg = r;
        bus.key_val = 4'(v);
    endtask

    task automatic idle_key();
        bus.key_strobe = 1'b0;
        bus.isdig = 1'b0;
        bus.isop = 1'b0;
        bus.isreg = 1'b0;
        bus.key_val = 4'd0;
    endtask

    // One key event; when it completes a command, also plays the ALU (delay cycles before done),
    // optionally strobes a digit during EXEC, or resets mid-EXEC instead of answering.
    task automatic key(input bit d, input bit o, input bit r, input int v,
                       input int delay, input bit poke, input bit do_reset);
        bit exp_err = 0;
        int kind = 0;
        int ea, eb, eop, dest, res;
        if (int'(d) + int'(o) + int'(r) != 1) begin
            exp_err = 1;
        end else if (d) begin
            if (v > 9) exp_err = 1;
            else if (!m_have_op) begin
                if (m_a.size() < DIGITS) m_a.push_back(v); else exp_err = 1;
            end else begin
                if (m_b.size() < DIGITS) m_b.push_back(v); else exp_err = 1;
            end
        end else if (o) begin
            if (m_a.size() == 0 || m_b.size() != 0) exp_err = 1;
            else begin
                m_have_op = 1;
                m_op = v;
            end
        end else begin
            if (m_a.size() == 0) exp_err = 1;
            else if (!m_have_op) kind = 1;
            else if (m_b.size() == 0) exp_err = 1;
            else kind = 2;
        end
        ea = q_value(m_a);
        eb = q_value(m_b);
        eop = m_op;
        dest = v % (1 << REG_AW);

        drive_key(d, o, r, v);
        tick();
        idle_key();
        check("err", bus.err, exp_err);

        if (kind == 1) begin
            check("store_we", bus.rf_we, 1);
            check("store_ready", bus.result_ready, 1);
            check("store_addr", bus.rf_waddr, dest);
            check("store_data", bus.rf_wdata, ea);
            check("store_no_alu", bus.alu_start, 0);
            tick();
            check("store_we_end", bus.rf_we, 0);
            check("store_busy_end", bus.busy, 0);
            model_clear();
        end else if (kind == 2) begin
            check("start", bus.alu_start, 1);
            check("alu_a", bus.alu_a, ea);
            check("alu_b", bus.alu_b, eb);
            check("alu_op", bus.alu_op, eop);
            check("busy_exec", bus.busy, 1);
            for (int i = 0; i < delay; i++) begin
                if (poke && i == 1) begin
                    drive_key(1, 0, 0, 5);
                    tick();
                    idle_key();
                    check("exec_key_err", bus.err, 0);
                end else begin
                    tick();
                end
                check("start_held", bus.alu_start, 1);
                check("alu_a_stable", bus.alu_a, ea);
                check("alu_b_stable", bus.alu_b, eb);
                check("busy_held", bus.busy, 1);
            end
            if (do_reset) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check("rst_start", bus.alu_start, 0);
                check("rst_busy", bus.busy, 0);
                check("rst_we", bus.rf_we, 0);
                tick();
                check("rst_we_after", bus.rf_we, 0);
                model_clear();
                return;
            end
            res = alu_model(eop, ea, eb);
            bus.alu_done = 1'b1;
            bus.alu_result = DATA_W'(res);
            tick();
            bus.alu_done = 1'b0;
            bus.alu_result = '0;
            check("wb_we", bus.rf_we, 1);
            check("wb_ready", bus.result_ready, 1);
            check("wb_addr", bus.rf_waddr, dest);
            check("wb_data", bus.rf_wdata, res);
            check("wb_busy", bus.busy, 1);
            check("wb_no_err", bus.err, 0);
            tick();
            check("wb_we_end", bus.rf_we, 0);
            check("wb_ready_end", bus.result_ready, 0);
            check("wb_busy_end", bus.busy, 0);
            model_clear();
        end else begin
            check("no_we", bus.rf_we, 0);
            check("no_start", bus.alu_start, 0);
        end
    endtask

    task automatic dig(input int v);
        key(1, 0, 0, v, 0, 0, 0);
    endtask

    task automatic opk(input int v);
        key(0, 1, 0, v, 0, 0, 0);
    endtask

    initial begin
        int sel, v, dl;
        bit pk, rs;
        rst = 1'b1;
        idle_key();
        bus.alu_done = 1'b0;
        bus.alu_result = '0;
        model_clear();
        tick();
        tick();
        check("rst_alu_start", bus.alu_start, 0);
        check("rst_rf_we", bus.rf_we, 0);
        check("rst_busy0", bus.busy, 0);
        check("rst_err", bus.err, 0);
        check("rst_ready", bus.result_ready, 0);
        check("rst_alu_a", bus.alu_a, 0);
        check("rst_alu_b", bus.alu_b, 0);
        check("rst_alu_op", bus.alu_op, 0);
        check("rst_waddr", bus.rf_waddr, 0);
        check("rst_wdata", bus.rf_wdata, 0);
        rst = 1'b0;
        tick();

        // 12 + 34 -> r2
        dig(1); dig(2); opk(0); dig(3); dig(4);
        key(0, 0, 1, 2, 2, 0, 0);
        // direct store 99 -> r1
        dig(9); dig(9);
        key(0, 0, 1, 1, 0, 0, 0);
        // illegal keys
        opk(5);
        key(0, 0, 1, 3, 0, 0, 0);
        dig(1); dig(2); dig(3);
        dig(11);
        key(1, 1, 0, 4, 0, 0, 0);
        key(0, 0, 0, 4, 0, 0, 0);
        opk(0); dig(3); dig(4);
        key(0, 0, 1, 3, 1, 0, 0);
        // operator replace: 7 * 3 -> r0
        dig(7); opk(0); opk(2); dig(3);
        key(0, 0, 1, 0, 0, 0, 0);
        // key during a slow EXEC, then a clean follow-up command
        dig(5); opk(1); dig(2);
        key(0, 0, 1, 3, 5, 1, 0);
        dig(4); opk(3); dig(6);
        key(0, 0, 1, 2, 1, 0, 0);
        // reset mid-EXEC, then a normal command
        dig(8); opk(0); dig(8);
        key(0, 0, 1, 1, 3, 0, 1);
        dig(2); dig(5); opk(2); dig(1); dig(1);
        key(0, 0, 1, 2, 2, 0, 0);

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 99);
            v = $urandom_range(0, 9);
            dl = $urandom_range(0, 4);
            pk = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 19) == 0);
            if (sel < 45)      key(1, 0, 0, v, dl, pk, rs);
            else if (sel < 50) key(1, 0, 0, $urandom_range(10, 15), dl, pk, rs);
            else if (sel < 68) key(0, 1, 0, $urandom_range(0, 15), dl, pk, rs);
            else if (sel < 88) key(0, 0, 1, $urandom_range(0, 15), dl, pk, rs);
            else if (sel < 93) key(0, 0, 0, v, dl, pk, rs);
            else               key(1, $urandom_range(0, 1), 1, v, dl, pk, rs);
            if ($urandom_range(0, 4) == 0) begin
                tick();
                check("idle_err", bus.err, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
